// File: rtl/icache_ctrl.sv
// Direct-mapped instruction cache controller: zero-cycle hit check, single-line
// fill from memory, and a one-index-per-cycle invalidate-all walk.
module icache_ctrl #(
  parameter int s_offset = 5,
  parameter int s_index  = 3,
  parameter int s_tag    = 32 - s_offset - s_index
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cpu_read,
  input  logic [31:0]        cpu_addr,
  input  logic               flush,
  output logic               cpu_resp,
  output logic               flush_busy,
  output logic [s_index-1:0] arr_index,
  input  logic [s_tag-1:0]   tag_in,
  input  logic               valid_in,
  output logic               tag_load,
  output logic               valid_load,
  output logic               data_load,
  output logic [s_tag-1:0]   tag_out,
  output logic               valid_out,
  output logic               mem_read,
  output logic [31:0]        mem_addr,
  input  logic               mem_resp,
  output logic [15:0]        hit_cnt,
  output logic [15:0]        miss_cnt
);

  typedef enum logic [1:0] {
    CHECK = 2'd0,
    FILL  = 2'd1,
    DONE  = 2'd2,
    FLUSH = 2'd3
  } state_t;

  localparam logic [31:0]        LINE_MASK = ~((32'd1 << s_offset) - 32'd1);
  localparam logic [s_index-1:0] LAST_SET  = '1;

  state_t             state_q, state_d;
  logic [31:0]        fill_addr_q, fill_addr_d;
  logic [s_index-1:0] walk_q, walk_d;
  logic [15:0]        hit_cnt_q, hit_cnt_d;
  logic [15:0]        miss_cnt_q, miss_cnt_d;

  logic [s_tag-1:0]   cpu_tag_s, fill_tag_s;
  logic [s_index-1:0] cpu_idx_s, fill_idx_s;
  logic               hit_s;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    if (v == 16'hFFFF) begin
      return v;
    end else begin
      return v + 16'd1;
    end
  endfunction

  assign cpu_tag_s  = cpu_addr[31 -: s_tag];
  assign cpu_idx_s  = cpu_addr[s_offset +: s_index];
  assign fill_tag_s = fill_addr_q[31 -: s_tag];
  assign fill_idx_s = fill_addr_q[s_offset +: s_index];
  assign hit_s      = valid_in && (tag_in == cpu_tag_s);
  assign hit_cnt    = hit_cnt_q;
  assign miss_cnt   = miss_cnt_q;

  // Next-state and array/memory handshake decode; all strobes default low.
  always_comb begin
    state_d     = state_q;
    fill_addr_d = fill_addr_q;
    walk_d      = walk_q;
    hit_cnt_d   = hit_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    cpu_resp    = 1'b0;
    flush_busy  = 1'b0;
    arr_index   = cpu_idx_s;
    tag_load    = 1'b0;
    valid_load  = 1'b0;
    data_load   = 1'b0;
    tag_out     = fill_tag_s;
    valid_out   = 1'b0;
    mem_read    = 1'b0;
    mem_addr    = fill_addr_q & LINE_MASK;
    case (state_q)
      CHECK: begin
        if (flush) begin
          state_d = FLUSH;
          walk_d  = '0;
        end else if (cpu_read && hit_s) begin
          cpu_resp  = 1'b1;
          hit_cnt_d = sat_inc(hit_cnt_q);
        end else if (cpu_read) begin
          fill_addr_d = cpu_addr;
          miss_cnt_d  = sat_inc(miss_cnt_q);
          state_d     = FILL;
        end else begin
          state_d = CHECK;
        end
      end
      FILL: begin
        arr_index = fill_idx_s;
        mem_read  = 1'b1;
        if (mem_resp) begin
          tag_load   = 1'b1;
          valid_load = 1'b1;
          data_load  = 1'b1;
          valid_out  = 1'b1;
          state_d    = DONE;
        end else begin
          state_d = FILL;
        end
      end
      DONE: begin
        arr_index = fill_idx_s;
        cpu_resp  = cpu_read;
        state_d   = CHECK;
      end
      FLUSH: begin
        arr_index  = walk_q;
        valid_load = 1'b1;
        flush_busy = 1'b1;
        if (walk_q == LAST_SET) begin
          state_d = CHECK;
        end else begin
          walk_d = walk_q + {{(s_index-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_d = CHECK;
      end
    endcase
  end

  // State, latched fill address, walk counter and performance counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= CHECK;
      fill_addr_q <= 32'd0;
      walk_q      <= '0;
      hit_cnt_q   <= 16'd0;
      miss_cnt_q  <= 16'd0;
    end else begin
      state_q     <= state_d;
      fill_addr_q <= fill_addr_d;
      walk_q      <= walk_d;
      hit_cnt_q   <= hit_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
    end
  end

endmodule

// File: tb/tb_icache_ctrl.sv
// Directed bench for icache_ctrl with a small tag/valid array model.
module tb_icache_ctrl;

  localparam int SO = 5;
  localparam int SI = 3;
  localparam int ST = 32 - SO - SI;

  logic          clk;
  logic          rst;
  logic          cpu_read;
  logic [31:0]   cpu_addr;
  logic          flush;
  logic          cpu_resp;
  logic          flush_busy;
  logic [SI-1:0] arr_index;
  logic [ST-1:0] tag_in;
  logic          valid_in;
  logic          tag_load, valid_load, data_load;
  logic [ST-1:0] tag_out;
  logic          valid_out;
  logic          mem_read;
  logic [31:0]   mem_addr;
  logic          mem_resp;
  logic [15:0]   hit_cnt, miss_cnt;

  logic [ST-1:0] tag_arr [8];
  logic          valid_arr [8];

  int checks;
  int failures;

  icache_ctrl #(.s_offset(SO), .s_index(SI)) dut (
    .clk(clk), .rst(rst), .cpu_read(cpu_read), .cpu_addr(cpu_addr), .flush(flush),
    .cpu_resp(cpu_resp), .flush_busy(flush_busy), .arr_index(arr_index),
    .tag_in(tag_in), .valid_in(valid_in), .tag_load(tag_load), .valid_load(valid_load),
    .data_load(data_load), .tag_out(tag_out), .valid_out(valid_out),
    .mem_read(mem_read), .mem_addr(mem_addr), .mem_resp(mem_resp),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign tag_in   = tag_arr[arr_index];
  assign valid_in = valid_arr[arr_index];

  always @(posedge clk) begin
    if (tag_load) tag_arr[arr_index] <= tag_out;
    if (valid_load) valid_arr[arr_index] <= valid_out;
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    for (int i = 0; i < 8; i++) begin
      tag_arr[i] = '0;
      valid_arr[i] = 1'b0;
    end
    rst = 1'b0; cpu_read = 1'b0; cpu_addr = 32'd0; flush = 1'b0; mem_resp = 1'b0;
    #3;
    check_eq("rst_busy", {31'd0, flush_busy}, 32'd0);
    check_eq("rst_mrd", {31'd0, mem_read}, 32'd0);
    check_eq("rst_hit", {16'd0, hit_cnt}, 32'd0);
    check_eq("rst_miss", {16'd0, miss_cnt}, 32'd0);
    tick();
    rst = 1'b1;
    tick();

    // Cold miss at 0x40 -> fill with two stall cycles.
    cpu_read = 1'b1; cpu_addr = 32'h0000_0040;
    #3;
    check_eq("miss_resp", {31'd0, cpu_resp}, 32'd0);
    check_eq("miss_idx", {29'd0, arr_index}, 32'd2);
    check_eq("miss_mrd0", {31'd0, mem_read}, 32'd0);
    tick();
    for (int c = 0; c < 3; c++) begin
      if (c == 2) mem_resp = 1'b1;
      #3;
      check_eq("fill_mrd", {31'd0, mem_read}, 32'd1);
      check_eq("fill_addr", mem_addr, 32'h0000_0040);
      check_eq("fill_idx", {29'd0, arr_index}, 32'd2);
      check_eq("fill_missc", {16'd0, miss_cnt}, 32'd1);
      check_eq("fill_resp", {31'd0, cpu_resp}, 32'd0);
      check_eq("fill_loads", {29'd0, tag_load, valid_load, data_load}, (c == 2) ? 32'd7 : 32'd0);
      if (c == 2) begin
        check_eq("fill_tag", {8'd0, tag_out}, 32'd0);
        check_eq("fill_vout", {31'd0, valid_out}, 32'd1);
      end
      tick();
    end
    mem_resp = 1'b0;
    #3;
    check_eq("done_resp", {31'd0, cpu_resp}, 32'd1);
    check_eq("done_mrd", {31'd0, mem_read}, 32'd0);
    check_eq("done_loads", {29'd0, tag_load, valid_load, data_load}, 32'd0);
    tick();
    cpu_read = 1'b0;
    tick();

    // Re-read of the filled line is a zero-cycle hit.
    cpu_read = 1'b1;
    #3;
    check_eq("hit_resp", {31'd0, cpu_resp}, 32'd1);
    check_eq("hit_mrd", {31'd0, mem_read}, 32'd0);
    tick();
    check_eq("hit_cnt1", {16'd0, hit_cnt}, 32'd1);
    check_eq("hit_miss1", {16'd0, miss_cnt}, 32'd1);
    cpu_read = 1'b0;
    mem_resp = 1'b1;
    #3;
    check_eq("stray_resp", {29'd0, tag_load, valid_load, data_load}, 32'd0);
    tick();
    mem_resp = 1'b0;

    // Flush wins over a concurrent hitting read; walk covers all 8 sets.
    cpu_read = 1'b1; flush = 1'b1;
    #3;
    check_eq("fl_prio", {31'd0, cpu_resp}, 32'd0);
    tick();
    flush = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == 3) flush = 1'b1;
      #3;
      check_eq("fl_busy", {31'd0, flush_busy}, 32'd1);
      check_eq("fl_idx", {29'd0, arr_index}, i);
      check_eq("fl_vld", {30'd0, valid_load, valid_out}, 32'd2);
      check_eq("fl_resp", {31'd0, cpu_resp}, 32'd0);
      tick();
      flush = 1'b0;
    end
    #3;
    check_eq("fl_end", {31'd0, flush_busy}, 32'd0);
    check_eq("fl_inval", {31'd0, cpu_resp}, 32'd0);
    tick();

    // Fill with 10-cycle memory latency; cpu_read drops in cycle 3.
    for (int c = 1; c <= 10; c++) begin
      if (c == 10) mem_resp = 1'b1;
      if (c == 5) flush = 1'b1;
      #3;
      check_eq("lat_mrd", {31'd0, mem_read}, 32'd1);
      check_eq("lat_busy", {31'd0, flush_busy}, 32'd0);
      if (c == 10) check_eq("lat_loads", {29'd0, tag_load, valid_load, data_load}, 32'd7);
      tick();
      flush = 1'b0;
      if (c == 3) cpu_read = 1'b0;
    end
    mem_resp = 1'b0;
    #3;
    check_eq("lat_done", {31'd0, cpu_resp}, 32'd0);
    check_eq("lat_miss", {16'd0, miss_cnt}, 32'd2);
    tick();

    // Reset in the middle of a fill.
    cpu_read = 1'b1; cpu_addr = 32'h1234_5677;
    tick();
    #3;
    check_eq("r_mrd", {31'd0, mem_read}, 32'd1);
    check_eq("r_addr", mem_addr, 32'h1234_5660);
    check_eq("r_idx", {29'd0, arr_index}, 32'd3);
    tick();
    #1;
    rst = 1'b0; mem_resp = 1'b1;
    #1;
    check_eq("r_mrd0", {31'd0, mem_read}, 32'd0);
    check_eq("r_loads", {29'd0, tag_load, valid_load, data_load}, 32'd0);
    check_eq("r_cnts", {hit_cnt, miss_cnt}, 32'd0);
    mem_resp = 1'b0; cpu_read = 1'b0;
    tick();
    rst = 1'b1;
    tick();

    // Back in CHECK: 0x40 still valid, so hits saturate the counter.
    cpu_read = 1'b1; cpu_addr = 32'h0000_0040;
    #3;
    check_eq("post_hit", {31'd0, cpu_resp}, 32'd1);
    tick();
    check_eq("sat_1", {16'd0, hit_cnt}, 32'd1);
    repeat (65533) tick();
    check_eq("sat_fffe", {16'd0, hit_cnt}, 32'h0000_FFFE);
    tick();
    tick();
    check_eq("sat_ffff", {16'd0, hit_cnt}, 32'h0000_FFFF);
    tick();
    check_eq("sat_hold", {16'd0, hit_cnt}, 32'h0000_FFFF);
    check_eq("sat_miss", {16'd0, miss_cnt}, 32'd0);
    cpu_read = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/icache_ctrl.md
ICACHE_CTRL -- requirements
Module: icache_ctrl

Interface
REQ-001 Parameter s_offset, default 5, byte-offset bits per line (32-byte line).
REQ-002 Parameter s_index, default 3, index bits; num_set = 2**s_index.
REQ-003 Parameter s_tag, default 32-s_offset-s_index, tag bits.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-low (0 = reset).
REQ-006 cpu_read  in  1  fetch request, held until cpu_resp.
REQ-007 cpu_addr  in  32  fetch byte address.
REQ-008 flush  in  1  invalidate-all request, one-cycle pulse.
REQ-009 cpu_resp  out  1  fetch complete; array dataout is valid this cycle.
REQ-010 flush_busy  out  1  invalidation walk in progress.
REQ-011 arr_index  out  s_index  index to tag, valid and data arrays.
REQ-012 tag_in  in  s_tag  tag array dataout at arr_index.
REQ-013 valid_in  in  1  valid array dataout at arr_index.
REQ-014 tag_load, valid_load, data_load  out  1 each  array write enables.
REQ-015 tag_out  out  s_tag  tag array datain; valid_out  out  1  valid array datain.
REQ-016 mem_read  out  1  line fill request to memory; mem_addr  out  32  line-aligned fill address.
REQ-017 mem_resp  in  1  fill line present on data array datain this cycle.
REQ-018 hit_cnt, miss_cnt  out  16 each  performance counters.

Function
REQ-019 FSM states SHALL be CHECK, FILL, DONE, FLUSH; reset state CHECK.
REQ-020 CHECK: arr_index = cpu_addr index field; hit = valid_in and tag_in == cpu_addr tag field.
REQ-021 CHECK, flush=1: go FLUSH, cpu_resp=0 that cycle; flush has priority over cpu_read.
REQ-022 CHECK, cpu_read=1, hit: cpu_resp=1 combinationally same cycle (zero-cycle hit), stay CHECK, hit_cnt += 1.
REQ-023 CHECK, cpu_read=1, miss: latch cpu_addr into fill register, go FILL, miss_cnt += 1, cpu_resp=0.
REQ-024 FILL: mem_read=1, mem_addr = latched address with low s_offset bits zero, arr_index from latched address; mem_read held until mem_resp.
REQ-025 FILL, mem_resp=1: tag_load=valid_load=data_load=1 same cycle, tag_out = latched tag, valid_out=1; go DONE.
REQ-026 DONE: arr_index from latched address, cpu_resp = cpu_read, no loads, mem_read=0; go CHECK next cycle.
REQ-027 cpu_read dropping during FILL SHALL NOT abort the fill; line still installed.
REQ-028 FLUSH: walk counter from 0 to num_set-1, one index per cycle; arr_index = counter, valid_load=1, valid_out=0, flush_busy=1; after index num_set-1 go CHECK (num_set cycles total).
REQ-029 FLUSH: cpu_resp=0, mem_read=0; flush pulses during FLUSH, FILL or DONE SHALL be ignored.
REQ-030 mem_resp outside FILL SHALL be ignored.
REQ-031 Counters SHALL saturate at 16'hFFFF, never wrap.
REQ-032 All loads, mem_read and cpu_resp SHALL be 0 in any state/condition not listed above.

Reset
REQ-033 rst=0 SHALL immediately force state CHECK, fill register, walk counter, hit_cnt, miss_cnt to 0; flush_busy=0 and mem_read=0 asynchronously.
REQ-034 Reset mid-FILL or mid-FLUSH SHALL abandon the operation with no array load issued; the controller does not invalidate arrays at reset.

Verification
REQ-035 Reset, arrays valid=0; cpu_read=1, addr 0x0000_0040 -> cycle 0 miss_cnt->1, FILL; mem_read=1, mem_addr 0x0000_0040 until mem_resp; load cycle tag_out=0, index 2; DONE cpu_resp=1.
REQ-036 Same address re-read after fill -> cpu_resp=1 in the request cycle, hit_cnt=1, no mem_read.
REQ-037 flush pulse in CHECK, num_set=8 -> flush_busy=1 for exactly 8 cycles, arr_index 0..7, valid_load=1, valid_out=0; concurrent cpu_read gets no cpu_resp until after.
REQ-038 mem_resp delayed 10 cycles, cpu_read dropped at cycle 3 of FILL -> mem_read held 10 cycles, loads asserted, DONE cpu_resp=0.
REQ-039 rst=0 asserted mid-FILL -> mem_read falls without clock edge, counters 0, no loads; after release, state CHECK.
REQ-040 Force hit_cnt to 16'hFFFE, two hits -> counter holds 16'hFFFF.
